// File: rtl/alu4_seq_ctrl_if.sv
// Bundle of the instruction, ALU and result signals of alu4_seq_ctrl.
// The controller connects through the slave modport; its environment uses master.
interface alu4_seq_ctrl_if;
    // Instruction handshake
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    // Downstream ALU: operands out, combinational results back
    logic [3:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_math_cin;
    logic        alu_rot_cin;
    logic [3:0]  alu_result;
    logic        alu_math_cout;
    logic        alu_rot_cout;
    logic        alu_ovf;
    logic        alu_zero;

    // Result handshake
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_data;
    logic [3:0]  res_flags;

    logic [7:0]  instr_count;

    modport master (
        output instr_valid, instr,
        input  instr_ready,
        input  alu_op, alu_a, alu_b, alu_math_cin, alu_rot_cin,
        output alu_result, alu_math_cout, alu_rot_cout, alu_ovf, alu_zero,
        input  res_valid, res_data, res_flags,
        output res_ready,
        input  instr_count
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready,
        output alu_op, alu_a, alu_b, alu_math_cin, alu_rot_cin,
        input  alu_result, alu_math_cout, alu_rot_cout, alu_ovf, alu_zero,
        output res_valid, res_data, res_flags,
        input  res_ready,
        output instr_count
    );
endinterface

// File: rtl/alu4_seq_ctrl.sv
// Sequencing controller for a 4-bit ALU: register file, flags and IDLE/EXEC/RESP FSM.
// Optional retired-instruction counter enabled by defining ALU4_SEQ_PERFCNT_EN.
module alu4_seq_ctrl #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic          clk,
    input  logic          rst,
    alu4_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] imm;
        logic       wb_en;
        logic       use_imm;
        logic [1:0] rb;
        logic [1:0] ra;
        logic [1:0] rd;
        logic [3:0] op;
    } instr_t;

    state_t     state;
    state_t     state_next;
    instr_t     ins;
    logic       accept;
    logic       retire;

    logic [3:0] regs [4];
    logic [3:0] flags;          // {V,Z,R,C}
    logic [3:0] alu_op_q;
    logic [3:0] alu_a_q;
    logic [3:0] alu_b_q;
    logic [1:0] rd_q;
    logic       wb_en_q;
    logic [3:0] res_data_q;

    assign ins = instr_t'(bus.instr);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next      = state;
        bus.instr_ready = 1'b0;
        bus.res_valid   = 1'b0;
        accept          = 1'b0;
        retire          = 1'b0;
        case (state)
            IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    retire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured at acceptance, so a source equal to rd sees the old
    // value and the next instruction sees the value written during EXEC.
    // NOTE: the register file is small and must read as zero after reset, so it
    // is reset like ordinary flops rather than left uninitialised like a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs       <= '{default: 4'h0};
            flags      <= RESET_FLAGS;
            alu_op_q   <= 4'h0;
            alu_a_q    <= 4'h0;
            alu_b_q    <= 4'h0;
            rd_q       <= 2'd0;
            wb_en_q    <= 1'b0;
            res_data_q <= 4'h0;
        end else begin
            if (accept) begin
                alu_op_q <= ins.op;
                alu_a_q  <= regs[ins.ra];
                alu_b_q  <= ins.use_imm ? ins.imm : regs[ins.rb];
                rd_q     <= ins.rd;
                wb_en_q  <= ins.wb_en;
            end
            if (state == EXEC) begin
                res_data_q <= bus.alu_result;
                flags      <= {bus.alu_ovf, bus.alu_zero, bus.alu_rot_cout, bus.alu_math_cout};
                if (wb_en_q) regs[rd_q] <= bus.alu_result;
            end
        end
    end

    assign bus.alu_op       = alu_op_q;
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.alu_math_cin = flags[0];
    assign bus.alu_rot_cin  = flags[1];
    assign bus.res_data     = res_data_q;
    assign bus.res_flags    = flags;

`ifdef ALU4_SEQ_PERFCNT_EN
    logic [7:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         count_q <= 8'h00;
        else if (retire) count_q <= count_q + 8'h01;
    end

    assign bus.instr_count = count_q;
`else
    logic unused_retire;

    assign unused_retire   = retire;
    assign bus.instr_count = 8'h00;
`endif

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Self-checking bench for alu4_seq_ctrl: transaction-level model, per-cycle compare,
// directed literal checks and randomized instruction traffic through a stub ALU.
module tb_alu4_seq_ctrl;

    localparam logic [3:0] RST_FLAGS = 4'b0011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu4_seq_ctrl_if bus ();

    alu4_seq_ctrl #(.RESET_FLAGS(RST_FLAGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Stub ALU: arbitrary but deterministic; result layout {V,Z,R,C,result[3:0]}
    logic       force_en  = 1'b0;
    logic [7:0] force_out = 8'h00;
    logic [7:0] alu_o;

    function automatic logic [7:0] stub_alu(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic mcin,
                                            input logic rcin);
        logic [4:0] s;
        logic [3:0] bx;
        logic       ovf;
        bx  = b ^ op;
        s   = {1'b0, a} + {1'b0, bx} + {4'b0000, mcin};
        ovf = (a[3] == bx[3]) && (s[3] != a[3]);
        return {ovf, (s[3:0] == 4'h0), a[3] ^ rcin ^ op[2], s[4], s[3:0]};
    endfunction

    always_comb begin
        alu_o             = force_en ? force_out
                          : stub_alu(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_math_cin, bus.alu_rot_cin);
        bus.alu_result    = alu_o[3:0];
        bus.alu_math_cout = alu_o[4];
        bus.alu_rot_cout  = alu_o[5];
        bus.alu_zero      = alu_o[6];
        bus.alu_ovf       = alu_o[7];
    end

    // Reference model state
    logic [3:0] m_regs [4];
    logic [3:0] m_flags, m_data, m_op, m_a, m_b;
    logic       m_ready, m_valid;
    logic [7:0] m_count;
    int         retired;
    bit         cmp_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb,
                                       input logic use_imm, input logic wb,
                                       input logic [3:0] imm);
        return {imm, wb, use_imm, rb, ra, rd, op};
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
        m_flags = RST_FLAGS;
        m_data  = 4'h0;
        m_op    = 4'h0;
        m_a     = 4'h0;
        m_b     = 4'h0;
        m_ready = 1'b1;
        m_valid = 1'b0;
        m_count = 8'h00;
        retired = 0;
    endtask

    // One instruction from IDLE back to IDLE; optionally reset during EXEC.
    task automatic issue(input logic [15:0] ins, input int hold, input bit rst_in_exec);
        logic [7:0] o;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        m_op    = ins[3:0];
        m_a     = m_regs[ins[7:6]];
        m_b     = ins[10] ? ins[15:12] : m_regs[ins[9:8]];
        m_ready = 1'b0;
        m_valid = 1'b0;
        bus.instr_valid = 1'($urandom);
        bus.instr       = 16'($urandom);
        if (rst_in_exec) begin
            #1 rst = 1'b1;
            reset_model();
            @(posedge clk); #1;
            rst             = 1'b0;
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        o       = force_en ? force_out : stub_alu(m_op, m_a, m_b, m_flags[0], m_flags[1]);
        m_flags = o[7:4];
        m_data  = o[3:0];
        if (ins[11]) m_regs[ins[5:4]] = o[3:0];
        m_valid       = 1'b1;
        bus.res_ready = 1'b0;
        repeat (hold) begin
            bus.instr_valid = 1'($urandom);
            bus.instr       = 16'($urandom);
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0;
        m_ready = 1'b1;
`ifdef ALU4_SEQ_PERFCNT_EN
        m_count = m_count + 8'h01;
`endif
        retired++;
        bus.res_ready   = 1'($urandom);
        bus.instr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("instr_ready", 8'(bus.instr_ready), 8'(m_ready));
            check("res_valid",   8'(bus.res_valid),   8'(m_valid));
            check("res_data",    8'(bus.res_data),    8'(m_data));
            check("res_flags",   8'(bus.res_flags),   8'(m_flags));
            check("carry_ins",   8'({bus.alu_rot_cin, bus.alu_math_cin}), 8'(m_flags[1:0]));
            check("alu_op",      8'(bus.alu_op), 8'(m_op));
            check("alu_a",       8'(bus.alu_a),  8'(m_a));
            check("alu_b",       8'(bus.alu_b),  8'(m_b));
            check("instr_count", bus.instr_count, m_count);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.res_ready   = 1'b0;
        reset_model();
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with RESET_FLAGS = 4'b0011
        check("rst_instr_ready", 8'(bus.instr_ready), 8'h01);
        check("rst_res_valid",   8'(bus.res_valid),   8'h00);
        check("rst_res_flags",   8'(bus.res_flags),   8'h03);
        check("rst_math_cin",    8'(bus.alu_math_cin), 8'h01);
        check("rst_rot_cin",     8'(bus.alu_rot_cin),  8'h01);
        rst = 1'b0;

        // op 5, imm 9, ra R0, rd R1, write back; ALU returns 7 with carry out
        force_en  = 1'b1;
        force_out = {4'b0001, 4'h7};
        issue(mk(4'h5, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 4'h9), 2, 1'b0);
        check("lit_alu_op",    8'(bus.alu_op),    8'h05);
        check("lit_alu_a",     8'(bus.alu_a),     8'h00);
        check("lit_alu_b",     8'(bus.alu_b),     8'h09);
        check("lit_res_data",  8'(bus.res_data),  8'h07);
        check("lit_res_flags", 8'(bus.res_flags), 8'h01);

        // Same instruction without write-back, held 5 cycles in RESP
        force_out = {4'b0000, 4'hA};
        issue(mk(4'h5, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 4'h9), 5, 1'b0);
        check("nowb_res_data",  8'(bus.res_data),     8'h0A);
        check("nowb_res_flags", 8'(bus.res_flags),    8'h00);
        check("nowb_math_cin",  8'(bus.alu_math_cin), 8'h00);
        force_en = 1'b0;
        issue(mk(4'h3, 2'd2, 2'd1, 2'd2, 1'b0, 1'b1, 4'h0), 0, 1'b0);
        check("read_r1", 8'(bus.alu_a), 8'h07);

        // Reset during EXEC drops the instruction
        issue(mk(4'h1, 2'd3, 2'd1, 2'd0, 1'b1, 1'b1, 4'h4), 0, 1'b1);
        check("exec_rst_flags", 8'(bus.res_flags),   8'(RST_FLAGS));
        check("exec_rst_ready", 8'(bus.instr_ready), 8'h01);
        issue(mk(4'h2, 2'd0, 2'd3, 2'd3, 1'b0, 1'b1, 4'h0), 1, 1'b0);
        check("after_rst_r3", 8'(bus.alu_a), 8'h00);

        // Random traffic, crossing the 256-retirement wrap
        for (int i = 0; i < 300; i++) begin
            issue(16'($urandom), int'($urandom_range(0, 3)), 1'b0);
            if (retired == 257) begin
`ifdef ALU4_SEQ_PERFCNT_EN
                check("count_257", bus.instr_count, 8'h01);
`else
                check("count_257", bus.instr_count, 8'h00);
`endif
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu4_seq_ctrl.md
ALU4_SEQ_CTRL -- requirements
Module: alu4_seq_ctrl

Interface
REQ-001 SHALL have parameter RESET_FLAGS, default 4'b0000, value loaded into the flag register {V,Z,R,C} on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port instr_valid, input, 1 bit: an instruction is offered.
REQ-005 SHALL have port instr_ready, output, 1 bit: the block accepts an instruction this cycle.
REQ-006 SHALL have port instr, input, 16 bits: [3:0] op, [5:4] rd, [7:6] ra, [9:8] rb, [10] use_imm, [11] wb_en, [15:12] imm.
REQ-007 SHALL have ports alu_op, alu_a and alu_b, outputs, 4 bits each: opcode and operands driven to the downstream ALU.
REQ-008 SHALL have ports alu_math_cin and alu_rot_cin, outputs, 1 bit each: carry-ins to the ALU.
REQ-009 SHALL have ports alu_result (input, 4 bits) and alu_math_cout, alu_rot_cout, alu_ovf, alu_zero (inputs, 1 bit each): combinational ALU outputs.
REQ-010 SHALL have ports res_valid (output, 1 bit) and res_ready (input, 1 bit): result handshake.
REQ-011 SHALL have ports res_data (output, 4 bits) and res_flags (output, 4 bits, {V,Z,R,C}): the retired result.
REQ-012 SHALL have port instr_count, output, 8 bits: retired-instruction count (see Configuration).

Function
REQ-013 SHALL hold a 4-entry x 4-bit register file R0..R3, a 4-bit flag register {V,Z,R,C}, and an FSM with states IDLE, EXEC and RESP.
REQ-014 IDLE SHALL drive instr_ready=1; on instr_valid=1, it SHALL latch op, rd and wb_en, latch alu_a=R[ra] and alu_b=(use_imm ? imm : R[rb]), and go to EXEC.
REQ-015 EXEC and RESP SHALL drive instr_ready=0, and instr SHALL be ignored in those states.
REQ-016 alu_op, alu_a and alu_b SHALL be registered and SHALL stay stable from the EXEC cycle until the next acceptance; alu_math_cin=C and alu_rot_cin=R, taken from the flag register.
REQ-017 EXEC SHALL last exactly one cycle; at its closing edge: res_data<=alu_result; flags<={alu_ovf,alu_zero,alu_rot_cout,alu_math_cout}; R[rd]<=alu_result only if wb_en=1; state->RESP.
REQ-018 The flag register SHALL update on every EXEC regardless of wb_en.
REQ-019 RESP SHALL drive res_valid=1 with res_data and res_flags held stable until res_ready=1, then go to IDLE on that edge.
REQ-020 Latency: accept at edge N, ALU sampled at edge N+1, res_valid=1 from the cycle after edge N+1; minimum 3 cycles per instruction.
REQ-021 A read of R[rd] by the next instruction SHALL see the value written by the previous instruction (no forwarding needed).
REQ-022 ra=rd or rb=rd SHALL read the old value; the write occurs only in EXEC.
REQ-023 res_valid SHALL be 0 in IDLE and EXEC; res_ready SHALL be ignored outside RESP.

Reset
REQ-024 When rst=1, the block SHALL immediately set state=IDLE, R0..R3=0, flags=RESET_FLAGS, alu_op/alu_a/alu_b=0, res_data=0 and instr_count=0.
REQ-025 Reset outputs SHALL be instr_ready=1, res_valid=0, res_flags=RESET_FLAGS, alu_math_cin=RESET_FLAGS[0] and alu_rot_cin=RESET_FLAGS[1].
REQ-026 Reset in EXEC or RESP SHALL drop the in-flight instruction with no register-file or flag write; the block SHALL accept a new instruction on the first edge after rst deasserts.

Configuration
REQ-027 With ALU4_SEQ_PERFCNT_EN defined, instr_count SHALL increment by 1, modulo 256, on each RESP->IDLE transition, wrapping 8'hFF->8'h00.
REQ-028 Without ALU4_SEQ_PERFCNT_EN, instr_count SHALL be tied to 8'h00, no counter flops SHALL exist, and the port list SHALL be unchanged.

Verification
REQ-029 Reset with RESET_FLAGS=4'b0011 -> instr_ready=1, res_valid=0, res_flags=4'b0011, alu_math_cin=1, alu_rot_cin=1.
REQ-030 Instr op=4'h5, use_imm=1, imm=4'h9, ra=R0, rd=R1, wb_en=1; ALU stub returns result 4'h7 with math_cout=1 -> alu_a=0, alu_b=9, alu_op=5 in EXEC; res_data=7 and res_flags C=1 two cycles after acceptance; a following read of R1 returns 7.
REQ-031 The same instruction with wb_en=0 -> R1 unchanged, flags still updated, and the next instruction's alu_math_cin equals the new C.
REQ-032 Hold res_ready=0 for 5 cycles in RESP -> res_valid, res_data and res_flags stable, instr_ready=0, and instr_valid pulses ignored.
REQ-033 Assert rst during EXEC -> no write to rd, flags=RESET_FLAGS, state IDLE, and the next instruction is accepted normally.
REQ-034 With ALU4_SEQ_PERFCNT_EN, retire 257 instructions -> instr_count=8'h01; without the macro, instr_count=8'h00 throughout.
